// File: rtl/mlp_layer_sequencer.sv
// Stage-1 address/control generator for the two-layer MLP datapath.
// Walks layer-1 then layer-2 (out, in) pairs emitting registered strobes.
module mlp_layer_sequencer #(
  parameter int N_IN        = 784,
  parameter int N_HID       = 64,
  parameter int N_OUT       = 10,
  parameter int IN_BASE     = 0,
  parameter int HID_BASE    = 1024,
  parameter int OUT_BASE    = 2048,
  parameter int WEIGHT_BASE = 0,
  parameter int PIPE_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        done_1,
  output logic [11:0] neuron_addr_1,
  output logic [15:0] weight_addr_1,
  output logic        reset_mult_acc_1,
  output logic        mac_en_1,
  output logic [11:0] out_neuron_addr_1,
  output logic        write_neuron_1
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_WRITE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [11:0] K0_LAST = 12'(N_IN - 1);
  localparam logic [11:0] K1_LAST = 12'(N_HID - 1);
  localparam logic [11:0] J0_LAST = 12'(N_HID - 1);
  localparam logic [11:0] J1_LAST = 12'(N_OUT - 1);
  localparam logic [11:0] D_LAST  = 12'(PIPE_DEPTH - 1);
  localparam logic [11:0] IB      = 12'(IN_BASE);
  localparam logic [11:0] HB      = 12'(HID_BASE);
  localparam logic [11:0] OB      = 12'(OUT_BASE);
  localparam logic [15:0] WB      = 16'(WEIGHT_BASE);

  state_t      state_q, state_d;
  logic [11:0] k_q, k_d;
  logic [11:0] j_q, j_d;
  logic [11:0] d_q, d_d;
  logic        layer_q, layer_d;
  logic [15:0] wptr_q, wptr_d;

  logic        done_d, rma_d, mac_d, wr_d;
  logic [11:0] na_d, oa_d;
  logic [15:0] wa_d;

  logic        beat;
  logic [11:0] bk;
  logic        bl;
  logic [15:0] bw;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    d_d     = d_q;
    layer_d = layer_q;
    wptr_d  = wptr_q;
    done_d  = 1'b0;
    rma_d   = 1'b0;
    mac_d   = 1'b0;
    wr_d    = 1'b0;
    na_d    = neuron_addr_1;
    wa_d    = weight_addr_1;
    oa_d    = out_neuron_addr_1;
    beat    = 1'b0;
    bk      = 12'd0;
    bl      = layer_q;
    bw      = wptr_q;

    if (!run) begin
      state_d = S_IDLE;
      k_d     = 12'd0;
      j_d     = 12'd0;
      d_d     = 12'd0;
      layer_d = 1'b0;
      wptr_d  = 16'd0;
      na_d    = 12'd0;
      wa_d    = 16'd0;
      oa_d    = 12'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_MAC;
          layer_d = 1'b0;
          j_d     = 12'd0;
          k_d     = 12'd0;
          beat    = 1'b1;
          bl      = 1'b0;
          bw      = WB;
        end
        S_MAC: begin
          if (k_q == (layer_q ? K1_LAST : K0_LAST)) begin
            state_d = S_WRITE;
            wr_d    = 1'b1;
            oa_d    = (layer_q ? OB : HB) + j_q;
          end else begin
            k_d  = k_q + 12'd1;
            beat = 1'b1;
            bk   = k_q + 12'd1;
          end
        end
        S_WRITE: begin
          if (j_q != (layer_q ? J1_LAST : J0_LAST)) begin
            state_d = S_MAC;
            j_d     = j_q + 12'd1;
            k_d     = 12'd0;
            beat    = 1'b1;
          end else if (!layer_q) begin
            state_d = S_DRAIN;
            d_d     = 12'd0;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        S_DRAIN: begin
          // wptr keeps running so layer-2 weights follow layer-1 ones
          if (d_q == D_LAST) begin
            state_d = S_MAC;
            layer_d = 1'b1;
            j_d     = 12'd0;
            k_d     = 12'd0;
            beat    = 1'b1;
            bl      = 1'b1;
          end else begin
            d_d = d_q + 12'd1;
          end
        end
        S_DONE: begin
          done_d = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      if (beat) begin
        mac_d  = 1'b1;
        rma_d  = (bk == 12'd0);
        na_d   = (bl ? HB : IB) + bk;
        wa_d   = bw;
        wptr_d = bw + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_IDLE;
      k_q               <= 12'd0;
      j_q               <= 12'd0;
      d_q               <= 12'd0;
      layer_q           <= 1'b0;
      wptr_q            <= 16'd0;
      done_1            <= 1'b0;
      neuron_addr_1     <= 12'd0;
      weight_addr_1     <= 16'd0;
      reset_mult_acc_1  <= 1'b0;
      mac_en_1          <= 1'b0;
      out_neuron_addr_1 <= 12'd0;
      write_neuron_1    <= 1'b0;
    end else begin
      state_q           <= state_d;
      k_q               <= k_d;
      j_q               <= j_d;
      d_q               <= d_d;
      layer_q           <= layer_d;
      wptr_q            <= wptr_d;
      done_1            <= done_d;
      neuron_addr_1     <= na_d;
      weight_addr_1     <= wa_d;
      reset_mult_acc_1  <= rma_d;
      mac_en_1          <= mac_d;
      out_neuron_addr_1 <= oa_d;
      write_neuron_1    <= wr_d;
    end
  end

endmodule
